// File: rtl/rr_arb4_sel.sv
// Four-requester round-robin arbiter with hold timeout; drives a 2x4 decoder
// through a registered index/enable pair with an idle gap between owners.
module rr_arb4_sel #(
    parameter int unsigned HOLD_W   = 4,
    parameter int unsigned MAX_HOLD = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] gnt_idx,
    output logic       gnt_en,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   last, last_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [HOLD_W-1:0]  hcnt, hcnt_nxt;
    logic               en_nxt, busy_nxt, to_nxt;
    logic [IDX_W-1:0]   winner, cand;
    logic               owner_rel;

    // Rotating priority: scan from farthest to nearest so the entry right after last wins.
    always_comb begin
        winner = last;
        cand   = last;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = last + IDX_W'(k);
            if (req[cand]) winner = cand;
        end
    end

    assign owner_rel = done || !req[gnt_idx];

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        idx_nxt   = gnt_idx;
        hcnt_nxt  = hcnt;
        en_nxt    = gnt_en;
        to_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    idx_nxt   = winner;
                    en_nxt    = 1'b1;
                    hcnt_nxt  = '0;
                end
            end
            GRANT: begin
                if (owner_rel || (hcnt == HOLD_LAST)) begin
                    state_nxt = GAP;
                    en_nxt    = 1'b0;
                    last_nxt  = gnt_idx;
                    to_nxt    = !owner_rel;
                end else begin
                    hcnt_nxt = hcnt + HOLD_W'(1);
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            last    <= 2'b11;
            hcnt    <= '0;
            gnt_idx <= 2'b00;
            gnt_en  <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            hcnt    <= hcnt_nxt;
            gnt_idx <= idx_nxt;
            gnt_en  <= en_nxt;
            busy    <= busy_nxt;
            timeout <= to_nxt;
        end
    end

endmodule
